// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module : ifu_pkg
// Desc   : Shared core package: fetch FSM state encoding and reset PC default.
// Rev    : 1.0  initial release
// ============================================================================
package ifu_pkg;

    // Default first fetch address after reset
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    // Byte stride between consecutive instructions
    localparam int unsigned IFU_PC_STEP = 4;

    // Fetch FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_e;

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
// Module : ifu
// Desc   : Instruction fetch unit. Issues one fetch at a time to instruction
//          memory, holds the returned instruction for the decode stage under
//          valid/ready, and handles redirects without ever changing an
//          already-issued request.
//          Optional performance counters are enabled by defining
//          YSYX_23060251_IFU_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst
`ifdef YSYX_23060251_IFU_PERF_EN
    ,
    output logic [63:0]     perf_fetch_cnt,
    output logic [63:0]     perf_stall_cnt
`endif
);

    localparam logic [XLEN-1:0] PC_INC    = XLEN'(IFU_PC_STEP);
    localparam logic [XLEN-1:0] PC_AT_RST = XLEN'(RESET_PC);

    ifu_state_e      state;
    ifu_state_e      state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] inst;
    logic            flush;
    logic            flush_next;
    logic            load_inst;
    logic            out_fire;

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = req_addr;
    assign out_valid      = (state == HOLD);
    assign out_pc         = pc;
    assign out_inst       = inst;
    assign out_fire       = out_valid & out_ready;

    // State, PC, flush flag, request address and instruction registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= PC_AT_RST;
            req_addr <= PC_AT_RST;
            flush    <= 1'b0;
            inst     <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            flush <= flush_next;
            // The request address is captured only on entry to REQ, so a
            // redirect while the request is pending cannot disturb it.
            if (state_next == REQ && state != REQ) begin
                req_addr <= pc_next;
            end
            if (load_inst) begin
                inst <= imem_rsp_data;
            end
        end
    end

    // Next-state, next-PC and flush-flag decision
    always_comb begin
        state_next = state;
        pc_next    = pc;
        flush_next = flush;
        load_inst  = 1'b0;
        unique case (state)
            IDLE: begin
                state_next = REQ;
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                end
            end
            REQ: begin
                // The request is already on the bus; retarget the PC and mark
                // the eventual response as stale.
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    flush_next = 1'b1;
                end
                if (imem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (redirect_valid || flush) begin
                        if (redirect_valid) begin
                            pc_next = redirect_pc;
                        end
                        flush_next = 1'b0;
                        state_next = REQ;
                    end else begin
                        load_inst  = 1'b1;
                        state_next = HOLD;
                    end
                end else if (redirect_valid) begin
                    // The response is still owed; stay until it arrives so it
                    // is not mistaken for the reply to the redirected fetch.
                    pc_next    = redirect_pc;
                    flush_next = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = REQ;
                end else if (out_ready) begin
                    pc_next    = pc + PC_INC;
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef YSYX_23060251_IFU_PERF_EN
    // Fetch and stall performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 64'd0;
            perf_stall_cnt <= 64'd0;
        end else begin
            if (out_fire) begin
                perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            end
            if (state == REQ || state == WAIT) begin
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
            end
        end
    end
`else
    logic unused_fire;
    assign unused_fire = out_fire;
`endif

endmodule : ifu
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// ============================================================================
// Module : tb_ifu
// Desc   : Directed self-checking bench for the instruction fetch unit.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ifu;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
`ifdef YSYX_23060251_IFU_PERF_EN
    logic [63:0]     perf_fetch_cnt;
    logic [63:0]     perf_stall_cnt;
`endif

    int total;
    int passed;

    ifu #(
        .RESET_PC (32'h8000_0000),
        .XLEN     (XLEN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
`ifdef YSYX_23060251_IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Directed sequence
    initial begin
        total          = 0;
        passed         = 0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        out_ready      = 1'b0;

        // Reset state
        repeat (2) step();
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'h0);
        check("rst_out_pc", 64'(out_pc), 64'h8000_0000);

        // Basic fetch: IDLE -> REQ -> WAIT -> HOLD
        rst = 1'b0;
        step();
        check("req0_valid", 64'(imem_req_valid), 64'd1);
        check("req0_addr", 64'(imem_req_addr), 64'h8000_0000);
        imem_req_ready = 1'b1;
        step();
        check("wait0_req_valid", 64'(imem_req_valid), 64'd0);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        step();
        imem_rsp_valid = 1'b0;
        check("hold0_valid", 64'(out_valid), 64'd1);
        check("hold0_pc", 64'(out_pc), 64'h8000_0000);
        check("hold0_inst", 64'(out_inst), 64'h0000_0013);

        // Back-pressure in HOLD for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_pc", 64'(out_pc), 64'h8000_0000);
            check("stall_inst", 64'(out_inst), 64'h0000_0013);
            check("stall_no_req", 64'(imem_req_valid), 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("req1_addr", 64'(imem_req_addr), 64'h8000_0004);
        check("req1_valid", 64'(imem_req_valid), 64'd1);
        check("req1_out_valid", 64'(out_valid), 64'd0);

        // Redirect coincident with out fire wins over +4
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0093;
        step();
        imem_rsp_valid = 1'b0;
        check("hold1_pc", 64'(out_pc), 64'h8000_0004);
        check("hold1_inst", 64'(out_inst), 64'h0010_0093);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        step();
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        check("redir_fire_addr", 64'(imem_req_addr), 64'h8000_0200);
        check("redir_fire_out_valid", 64'(out_valid), 64'd0);

        // Redirect while the request is stalled: address held, response dropped
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            redirect_valid = (i == 1);
            redirect_pc    = 32'h8000_0100;
            step();
            check("stall_req_addr", 64'(imem_req_addr), 64'h8000_0200);
            check("stall_req_valid", 64'(imem_req_valid), 64'd1);
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_req_addr", 64'(imem_req_addr), 64'h8000_0100);
        check("flush_req_valid", 64'(imem_req_valid), 64'd1);
        check("flush_inst_kept", 64'(out_inst), 64'h0010_0093);

        // Redirect coincident with response in WAIT
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        step();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        check("wait_redir_out_valid", 64'(out_valid), 64'd0);
        check("wait_redir_addr", 64'(imem_req_addr), 64'h8000_0300);

        // Redirect in HOLD without fire
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0517;
        step();
        imem_rsp_valid = 1'b0;
        check("hold2_pc", 64'(out_pc), 64'h8000_0300);
        check("hold2_inst", 64'(out_inst), 64'h0000_0517);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0400;
        step();
        redirect_valid = 1'b0;
        check("hold_redir_out_valid", 64'(out_valid), 64'd0);
        check("hold_redir_addr", 64'(imem_req_addr), 64'h8000_0400);

        // Asynchronous reset while waiting for a response
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_req_valid", 64'(imem_req_valid), 64'd0);
        check("arst_out_inst", 64'(out_inst), 64'h0);
        check("arst_out_pc", 64'(out_pc), 64'h8000_0000);
        step();
        rst = 1'b0;
        step();
        check("arst_req_addr", 64'(imem_req_addr), 64'h8000_0000);
        check("arst_req_valid2", 64'(imem_req_valid), 64'd1);

        // Zero-wait memory streaming: 10 fetches in 30 cycles
        rst = 1'b1;
        step();
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        out_ready      = 1'b1;
        repeat (31) step();
        check("stream_req_addr", 64'(imem_req_addr), 64'h8000_0028);
        check("stream_req_valid", 64'(imem_req_valid), 64'd1);
`ifdef YSYX_23060251_IFU_PERF_EN
        check("perf_fetch", perf_fetch_cnt, 64'd10);
        check("perf_stall", perf_stall_cnt, 64'd20);
`endif
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        out_ready      = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_ifu
`default_nettype wire
